// File: rtl/approx_pkg.sv
// Shared definitions for the pipelined lower-part-OR approximate adder:
// mode encodings and the generic approximate lower-part function.
package approx_pkg;

    typedef enum logic {
        MODE_APPROX = 1'b0,
        MODE_EXACT  = 1'b1
    } addMode_e;

    // Widest operand the generic helper below can handle.
    localparam int MAX_W = 64;

    // Bit i of the result is 1 if any generate (a&b) exists at or above i
    // inside the approximate part, otherwise the propagate (a|b) bit.
    // Bits at or above k are returned as zero.
    function automatic logic [MAX_W-1:0] approx_lower(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               k
    );
        logic [MAX_W-1:0] lo;
        logic             fill;
        lo   = '0;
        fill = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < k) begin
                fill  = fill | (a[i] & b[i]);
                lo[i] = fill | a[i] | b[i];
            end
        end
        return lo;
    endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational W/K adder: returns the unwrapped (W+1)-bit approximate and
// exact sums of the same operands.
module approx_add_core
    import approx_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 12
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   approx_o,
    output logic [W:0]   exact_o
);

    assign exact_o = {1'b0, a_i} + {1'b0, b_i};

    generate
        if (K == 0) begin : g_pure_exact
            assign approx_o = exact_o;
        end else begin : g_split
            logic [W-K:0] hi;
            logic [K-1:0] lo;

            // The upper part deliberately ignores any carry out of the lower part.
            assign hi = {1'b0, a_i[W-1:K]} + {1'b0, b_i[W-1:K]};
            assign lo = K'(approx_lower(MAX_W'(a_i), MAX_W'(b_i), K));
            assign approx_o = {hi, lo};
        end
    endgenerate

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready pipeline around approx_add_core with per-beat mode.
// Define APPROX_ERR_EN to add the out_err / err_cnt / err_clr error monitor.
module approx_adder_pipe
    import approx_pkg::*;
#(
    parameter int W     = 16,
    parameter int K     = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic             out_mode
`ifdef APPROX_ERR_EN
    ,
    output logic [W:0]       out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
`endif
);

    logic         s1Valid_q;
    logic [W-1:0] s1A_q;
    logic [W-1:0] s1B_q;
    logic         s1Mode_q;

    logic         s2Valid_q;
    logic [W-1:0] s2Sum_q;
    logic         s2Cout_q;
    logic         s2Mode_q;

    logic         s1Adv;
    logic         s2Adv;
    logic [W:0]   approxSum;
    logic [W:0]   exactSum;
    logic [W:0]   selSum_d;
    logic [W:0]   err_d;

    // No skid buffer: upstream sees backpressure in the same cycle.
    assign s2Adv    = !s2Valid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = s1Adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
            s1Mode_q  <= MODE_APPROX;
        end else if (s1Adv) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1A_q    <= in_a;
                s1B_q    <= in_b;
                s1Mode_q <= in_mode;
            end
        end
    end

    approx_add_core #(
        .W (W),
        .K (K)
    ) u_core (
        .a_i      (s1A_q),
        .b_i      (s1B_q),
        .approx_o (approxSum),
        .exact_o  (exactSum)
    );

    always_comb begin
        selSum_d = (s1Mode_q == MODE_EXACT) ? exactSum : approxSum;
        err_d    = exactSum - selSum_d;
    end

    // Data registers only load on a real beat so out_* keeps its last value
    // through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid_q <= 1'b0;
            s2Sum_q   <= '0;
            s2Cout_q  <= 1'b0;
            s2Mode_q  <= MODE_APPROX;
        end else if (s2Adv) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Sum_q  <= selSum_d[W-1:0];
                s2Cout_q <= selSum_d[W];
                s2Mode_q <= s1Mode_q;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign out_sum   = s2Sum_q;
    assign out_cout  = s2Cout_q;
    assign out_mode  = s2Mode_q;

`ifdef APPROX_ERR_EN
    logic [W:0]       s2Err_q;
    logic [CNT_W-1:0] errCnt_q;
    logic [CNT_W-1:0] errCnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Err_q <= '0;
        end else if (s2Adv && s1Valid_q) begin
            s2Err_q <= err_d;
        end
    end

    // Clear beats a same-cycle count; the count saturates at all-ones.
    always_comb begin
        errCnt_d = errCnt_q;
        if (err_clr) begin
            errCnt_d = '0;
        end else if (s2Valid_q && out_ready && (s2Err_q != '0) && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign out_err = s2Err_q;
    assign err_cnt = errCnt_q;
`else
    logic unusedErr;
    assign unusedErr = ^err_d;
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed self-checking bench for approx_adder_pipe (W=16, K=12); the
// error-monitor checks are compiled in when APPROX_ERR_EN is defined.
module tb_approx_adder_pipe;

    localparam int W     = 16;
    localparam int K     = 12;
    localparam int CNT_W = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_mode;
`ifdef APPROX_ERR_EN
    logic [W:0]       out_err;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    logic [W-1:0] obsSum;
    logic         obsCout;
    logic         obsMode;
    logic [W:0]   obsErr;

    // Stream vectors with hand-computed results (K=12).
    logic [W-1:0] vecA    [8] = '{16'h0FFF, 16'h0FFF, 16'h1234, 16'h1234, 16'hFFFF, 16'hF000, 16'h8001, 16'h00FF};
    logic [W-1:0] vecB    [8] = '{16'h0001, 16'h0001, 16'h1111, 16'h1111, 16'h0001, 16'h1000, 16'h8001, 16'h0F01};
    logic         vecMode [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] expSum  [8] = '{16'h0FFF, 16'h1000, 16'h233F, 16'h2345, 16'h0000, 16'h0000, 16'h0001, 16'h1000};
    logic         expCout [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W:0]   expErr  [8] = '{17'h1, 17'h0, 17'h6, 17'h0, 17'h0, 17'h0, 17'h1, 17'h0};

    approx_adder_pipe #(
        .W     (W),
        .K     (K),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_mode  (out_mode)
`ifdef APPROX_ERR_EN
        ,
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated beat with out_ready held high: checks acceptance and the
    // 2-cycle latency, then captures the result fields.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic mode);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_mode   = mode;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("idle_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("lat1_valid", out_valid, 0);
        @(negedge clk);
        checkOutput("lat2_valid", out_valid, 1);
        obsSum  = out_sum;
        obsCout = out_cout;
        obsMode = out_mode;
`ifdef APPROX_ERR_EN
        obsErr  = out_err;
`else
        obsErr  = '0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int got;
        int occ;
        int cyc;
        logic accIn;
        logic accOut;
        logic stallPrev;
        logic [W-1:0] prevSum;
        logic prevCout;
        logic prevMode;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
`ifdef APPROX_ERR_EN
        err_clr   = 1'b0;
`endif
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_sum", out_sum, 0);
        checkOutput("rst_cout", out_cout, 0);
        checkOutput("rst_mode", out_mode, 0);
        #11;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Directed single beats
        applyStimulus(16'h0FFF, 16'h0001, 1'b0);
        checkOutput("t1_sum", obsSum, 16'h0FFF);
        checkOutput("t1_cout", obsCout, 0);
        checkOutput("t1_mode", obsMode, 0);
`ifdef APPROX_ERR_EN
        checkOutput("t1_err", obsErr, 1);
        checkOutput("t1_cnt", err_cnt, 1);
`endif
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        checkOutput("t2_sum", obsSum, 16'h233F);
`ifdef APPROX_ERR_EN
        checkOutput("t2_err", obsErr, 6);
        checkOutput("t2_cnt", err_cnt, 2);
`endif
        applyStimulus(16'h1234, 16'h1111, 1'b1);
        checkOutput("t3_sum", obsSum, 16'h2345);
        checkOutput("t3_mode", obsMode, 1);
`ifdef APPROX_ERR_EN
        checkOutput("t3_err", obsErr, 0);
        checkOutput("t3_cnt", err_cnt, 2);
`endif
        applyStimulus(16'hFFFF, 16'h0001, 1'b1);
        checkOutput("t4_sum", obsSum, 16'h0000);
        checkOutput("t4_cout", obsCout, 1);
        applyStimulus(16'hF000, 16'h1000, 1'b0);
        checkOutput("t5_sum", obsSum, 16'h0000);
        checkOutput("t5_cout", obsCout, 1);
`ifdef APPROX_ERR_EN
        checkOutput("t5_err", obsErr, 0);
        checkOutput("t5_cnt", err_cnt, 2);
`endif

        // Back-to-back mixed stream with out_ready toggling 1,0,1,0...
        idx = 0; got = 0; occ = 0; cyc = 0; stallPrev = 1'b0;
        prevSum = '0; prevCout = 1'b0; prevMode = 1'b0;
        while ((got < 8) && (cyc < 100)) begin
            @(negedge clk);
            out_ready = (cyc % 2 == 0);
            if (idx < 8) begin
                in_valid = 1'b1;
                in_a     = vecA[idx];
                in_b     = vecB[idx];
                in_mode  = vecMode[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stallPrev) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_sum", out_sum, prevSum);
                checkOutput("stall_cout", out_cout, prevCout);
                checkOutput("stall_mode", out_mode, prevMode);
            end
            checkOutput("stream_in_ready", in_ready, !((occ == 2) && !out_ready));
            accIn  = in_valid && in_ready;
            accOut = out_valid && out_ready;
            if (accOut) begin
                checkOutput("stream_sum", out_sum, expSum[got]);
                checkOutput("stream_cout", out_cout, expCout[got]);
                checkOutput("stream_mode", out_mode, vecMode[got]);
`ifdef APPROX_ERR_EN
                checkOutput("stream_err", out_err, expErr[got]);
`endif
                got++;
            end
            stallPrev = out_valid && !out_ready;
            prevSum   = out_sum;
            prevCout  = out_cout;
            prevMode  = out_mode;
            if (accIn) idx++;
            occ = occ + int'(accIn) - int'(accOut);
            cyc++;
        end
        checkOutput("stream_count", got, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("stream_drained", out_valid, 0);
`ifdef APPROX_ERR_EN
        checkOutput("stream_cnt_sat", err_cnt, 3);
`endif

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h0001;
        in_b      = 16'h0002;
        in_mode   = 1'b1;
        @(negedge clk);
        in_a = 16'h0005;
        in_b = 16'h0006;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("full_valid", out_valid, 1);
        checkOutput("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_sum", out_sum, 0);
`ifdef APPROX_ERR_EN
        checkOutput("async_rst_cnt", err_cnt, 0);
`endif
        #1;
        rst_n = 1'b1;
        applyStimulus(16'h0003, 16'h0004, 1'b1);
        checkOutput("post_rst_sum", obsSum, 16'h0007);
        @(negedge clk);
        checkOutput("post_rst_empty", out_valid, 0);

`ifdef APPROX_ERR_EN
        // Saturation with CNT_W=2, then clear racing a counted handshake
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h0FFF, 16'h0001, 1'b0);
            if (i == 1) checkOutput("sat_cnt2", err_cnt, 2);
        end
        checkOutput("sat_cnt", err_cnt, 3);
        @(negedge clk);
        in_a      = 16'h0FFF;
        in_b      = 16'h0001;
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("clr_beat_valid", out_valid, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        checkOutput("clr_wins", err_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
